// File: rtl/i2s_sample_rx.sv
// i2s_sample_rx: I2S slave receiver. Brings SCK/WS/SD into the clk domain,
// deserializes each channel word MSB-first and presents it left-justified on
// sample with a one-cycle sample_valid pulse. Short words raise frame_err.
// Build option: define STEREO_EN to deliver both channels; otherwise only
// left-channel words are delivered (mono).
module i2s_sample_rx #(
   parameter int DATA_WIDTH = 16,
   parameter int SLOT_MAX   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i2s_sck,
   input  logic                  i2s_ws,
   input  logic                  i2s_sd,
   output logic [DATA_WIDTH-1:0] sample,
   output logic                  sample_valid,
   output logic                  sample_right,
   output logic                  frame_err
);

   localparam int CW    = $clog2(SLOT_MAX + 1);
   localparam int CNT_W = CW + 1;
   localparam logic [CNT_W-1:0] DW_C   = CNT_W'(DATA_WIDTH);
   localparam logic [CW-1:0]    SLOT_C = CW'(SLOT_MAX);

   typedef enum logic {ALIGN, RUN} state_t;

   state_t                state, state_nxt;
   logic                  sck_s1, sck_s2, sck_s3;
   logic                  ws_s1, ws_s2;
   logic                  sd_s1, sd_s2;
   logic                  ws_prev;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift;

   logic                  rise;
   logic                  ws_chg;
   logic                  word_done;
   logic                  deliver;
   logic [DATA_WIDTH-1:0] shift_in;
   logic [CNT_W-1:0]      cnt_ext;
   logic [CNT_W-1:0]      n_raw;
   logic [CNT_W-1:0]      n_bits;
   logic [DATA_WIDTH-1:0] word_out;
   logic [CW-1:0]         cnt_inc;

   // Two-flop synchronizers on all pins plus a third SCK flop for edge detect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_s3 <= 1'b0;
         ws_s1  <= 1'b0; ws_s2  <= 1'b0;
         sd_s1  <= 1'b0; sd_s2  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its
         // predecessor; blocking here would collapse the synchronizer chain.
         sck_s1 <= i2s_sck; sck_s2 <= sck_s1; sck_s3 <= sck_s2;
         ws_s1  <= i2s_ws;  ws_s2  <= ws_s1;
         sd_s1  <= i2s_sd;  sd_s2  <= sd_s1;
      end
   end

   assign rise   = sck_s2 & ~sck_s3;
   assign ws_chg = ws_s2 != ws_prev;

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ALIGN;
      else       state <= state_nxt;
   end

   // Next state and word-completion decode: a WS change on an SCK rise ends a word.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_nxt = state;
      word_done = 1'b0;
      deliver   = 1'b0;
      if (rise && ws_chg) begin
         state_nxt = RUN;
         if (state == RUN) begin
            word_done = 1'b1;
`ifdef STEREO_EN
            deliver = 1'b1;
`else
            deliver = ~ws_prev;
`endif
         end
      end
   end

   // Word assembly: append the current bit while room remains, then left-justify.
   always_comb begin
      cnt_ext  = {1'b0, bit_cnt};
      shift_in = (cnt_ext < DW_C) ? {shift[DATA_WIDTH-2:0], sd_s2} : shift;
      n_raw    = cnt_ext + CNT_W'(1);
      n_bits   = (n_raw > DW_C) ? DW_C : n_raw;
      word_out = shift_in << (DW_C - n_bits);
      cnt_inc  = (bit_cnt == SLOT_C) ? bit_cnt : bit_cnt + CW'(1);
   end

   // Shift register, bit counter, WS history and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ws_prev      <= 1'b0;
         bit_cnt      <= '0;
         shift        <= '0;
         sample       <= '0;
         sample_right <= 1'b0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         if (rise) begin
            ws_prev <= ws_s2;
            if (ws_chg) begin
               // Either alignment or end of word: start a fresh word.
               bit_cnt <= '0;
               shift   <= '0;
               if (word_done) begin
                  frame_err <= n_bits < DW_C;
                  if (deliver) begin
                     sample       <= word_out;
                     sample_right <= ws_prev;
                     sample_valid <= 1'b1;
                  end
               end
            end else if (state == RUN) begin
               shift   <= shift_in;
               bit_cnt <= cnt_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Testbench for i2s_sample_rx: drives I2S word streams and compares the
// delivered words against a word-level reference model.
module tb_i2s_sample_rx;

   localparam int DW = 16;
`ifdef STEREO_EN
   localparam bit STEREO = 1'b1;
`else
   localparam bit STEREO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          i2s_sck, i2s_ws, i2s_sd;
   logic [DW-1:0] sample;
   logic          sample_valid, sample_right, frame_err;

   typedef struct {
      logic        right;
      logic [39:0] bits;
      int          len;
   } word_t;

   typedef struct packed {
      logic          valid;
      logic          err;
      logic [DW-1:0] smp;
      logic          right;
   } evt_t;

   word_t words[$];
   evt_t  got_q[$];
   evt_t  exp_q[$];
   int    vectors     = 0;
   int    miscompares = 0;
   logic  prev_valid  = 1'b0;
   logic  next_right  = 1'b0;

   i2s_sample_rx #(.DATA_WIDTH(16), .SLOT_MAX(32)) dut (
      .clk(clk), .reset(reset),
      .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
      .sample(sample), .sample_valid(sample_valid),
      .sample_right(sample_right), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Monitor: record every pulse and check sample_valid never lasts two cycles.
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (prev_valid) begin
            vectors++;
            if (sample_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL valid_width: sample_valid=%b on cycle after pulse, required 0", sample_valid);
            end
         end
         if (sample_valid === 1'b1 || frame_err === 1'b1)
            got_q.push_back('{sample_valid, frame_err, sample, sample_right});
         prev_valid = sample_valid;
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset = 1'b1; i2s_sck = 1'b0; i2s_ws = 1'b0; i2s_sd = 1'b0;
      #33;
      reset = 1'b0;
      #20;
      words.delete(); got_q.delete();
      next_right = 1'b0;
   endtask

   // Queue words with alternating channels, starting with left after reset.
   task automatic add_word(input logic [39:0] bits, input int len);
      words.push_back('{next_right, bits, len});
      next_right = ~next_right;
   endtask

   task automatic sck_period(input logic ws_v, input logic sd_v);
      i2s_sck = 1'b0; i2s_ws = ws_v; i2s_sd = sd_v;
      #40;
      i2s_sck = 1'b1;
      #40;
   endtask

   // WS takes a word's channel for all its bits except the LSB, which already
   // carries the next channel's WS value.
   task automatic drive_words();
      logic last_ws = 1'b0;
      foreach (words[k]) begin
         for (int j = 0; j < words[k].len; j++) begin
            last_ws = (j == words[k].len - 1) ? ~words[k].right : words[k].right;
            sck_period(last_ws, words[k].bits[words[k].len - 1 - j]);
         end
      end
      for (int j = 0; j < 3; j++) sck_period(last_ws, 1'b0);
      i2s_sck = 1'b0;
      #200;
   endtask

   // Reference model: the first word after reset only aligns; each later word
   // yields its first min(len,DW) bits left-justified; mono drops right words.
   task automatic build_expected();
      logic [63:0]   t;
      logic [DW-1:0] held_smp   = '0;
      logic          held_right = 1'b0;
      logic          v, e;
      int            n;
      exp_q.delete();
      for (int k = 1; k < words.size(); k++) begin
         t = words[k].bits & ((64'd1 << words[k].len) - 64'd1);
         n = (words[k].len < DW) ? words[k].len : DW;
         if (words[k].len >= DW) t = t >> (words[k].len - DW);
         else                    t = t << (DW - words[k].len);
         e = (n < DW);
         v = STEREO || !words[k].right;
         if (v) begin
            held_smp   = t[DW-1:0];
            held_right = words[k].right;
         end
         if (v || e) exp_q.push_back('{v, e, held_smp, held_right});
      end
   endtask

   task automatic compare_stream(input string name);
      int cnt;
      build_expected();
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL %s_count: got %0d events, required %0d", name, got_q.size(), exp_q.size());
      end
      cnt = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < cnt; i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL %s_evt%0d: got valid=%b err=%b sample=%h right=%b, required valid=%b err=%b sample=%h right=%b",
                     name, i, got_q[i].valid, got_q[i].err, got_q[i].smp, got_q[i].right,
                     exp_q[i].valid, exp_q[i].err, exp_q[i].smp, exp_q[i].right);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 200; i++) begin
         i2s_sck = 1'($urandom); i2s_ws = 1'($urandom); i2s_sd = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         vectors++;
         if ({sample, sample_valid, sample_right, frame_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: sample=%h valid=%b right=%b err=%b, required all 0",
                     sample, sample_valid, sample_right, frame_err);
         end
      end
   endtask

   task automatic test_fixed_frames();
      do_reset();
      for (int f = 0; f < 4; f++) begin
         add_word({8'h00, 16'hA5C3, 16'h0000}, 32);
         add_word({8'h00, 16'h1234, 16'h0000}, 32);
      end
      drive_words();
      compare_stream("fixed_frames");
   endtask

   task automatic test_wide_slot();
      do_reset();
      for (int f = 0; f < 3; f++) begin
         add_word({16'h0000, 24'h7FFF01}, 24);
         add_word({16'h0000, 24'($urandom)}, 24);
      end
      drive_words();
      compare_stream("wide_slot");
   endtask

   task automatic test_short_word();
      do_reset();
      add_word(40'($urandom), 16);
      add_word(40'($urandom), 16);
      add_word(40'hC5, 8);
      add_word(40'($urandom), 16);
      add_word(40'($urandom), 16);
      add_word(40'h5, 4);
      add_word(40'($urandom), 16);
      drive_words();
      compare_stream("short_word");
   endtask

   task automatic test_reset_mid_word();
      do_reset();
      for (int j = 0; j < 10; j++) sck_period(1'b0, 1'($urandom));
      i2s_sck = 1'b0;
      reset = 1'b1;
      #27;
      reset = 1'b0;
      #20;
      words.delete(); got_q.delete();
      next_right = 1'b0;
      add_word(40'($urandom), 6);
      add_word(40'($urandom), 16);
      add_word(40'h8001, 16);
      add_word(40'($urandom), 16);
      add_word(40'h8001, 16);
      add_word(40'($urandom), 16);
      drive_words();
      compare_stream("reset_mid_word");
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 30; k++)
         add_word({8'($urandom), 32'($urandom)}, int'($urandom_range(2, 40)));
      drive_words();
      compare_stream("random");
   endtask

   initial begin
      i2s_sck = 1'b0; i2s_ws = 1'b0; i2s_sd = 1'b0;
      test_reset();
      test_fixed_frames();
      test_wide_slot();
      test_short_word();
      test_reset_mid_word();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
